// File: rtl/wb_result_arbiter_if.sv
// Writeback arbitration bundle: pipeline W-stage result, MCU handshake and register-file write side.
// WaitCount (and the CW parameter feeding it) exist only when WB_ARB_PERF_EN is defined.
interface wb_result_arbiter_if
`ifdef WB_ARB_PERF_EN
  #(parameter int CW = 3)
`endif
  ;
  logic       PipeValidW;
  logic [1:0] PipeResultSrcW;
  logic [4:0] PipeRdW;
  logic       McuValid;
  logic [4:0] McuRd;
  logic       McuReady;
  logic       StallW;
  logic [2:0] ResultSel;
  logic       RegWriteW;
  logic [4:0] RdW;
`ifdef WB_ARB_PERF_EN
  logic [CW-1:0] WaitCount;

  modport master (output PipeValidW, PipeResultSrcW, PipeRdW, McuValid, McuRd,
                  input  McuReady, StallW, ResultSel, RegWriteW, RdW, WaitCount);
  modport slave  (input  PipeValidW, PipeResultSrcW, PipeRdW, McuValid, McuRd,
                  output McuReady, StallW, ResultSel, RegWriteW, RdW, WaitCount);
`else
  modport master (output PipeValidW, PipeResultSrcW, PipeRdW, McuValid, McuRd,
                  input  McuReady, StallW, ResultSel, RegWriteW, RdW);
  modport slave  (input  PipeValidW, PipeResultSrcW, PipeRdW, McuValid, McuRd,
                  output McuReady, StallW, ResultSel, RegWriteW, RdW);
`endif
endinterface

// File: rtl/wb_result_arbiter.sv
// Writeback port arbiter: pipeline W result vs one multi-cycle unit, pipeline first, MCU forced after STARVE_LIMIT losses.
// Latency: McuReady/StallW combinational; ResultSel/RegWriteW/RdW registered one cycle after the grant.
// Backpressure: MCU holds McuValid until McuReady; a forced MCU grant stalls W. WB_ARB_PERF_EN adds WaitCount.
module wb_result_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CW           = 3
) (
  input logic                 clk,
  input logic                 reset,
  wb_result_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FORCE} state_t;

  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pipe_grant, mcu_grant, stall;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pipe_grant = 1'b0;
    mcu_grant  = 1'b0;
    stall      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.PipeValidW) begin
          pipe_grant = 1'b1;
          if (bus.McuValid) begin
            cnt_nxt   = CW'(1);
            state_nxt = (LIMIT == CW'(1)) ? ST_FORCE : ST_WAIT;
          end
        end else if (bus.McuValid) begin
          mcu_grant = 1'b1;
        end
      end
      ST_WAIT: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        if (!bus.McuValid) begin
          // MCU withdrew its result: drop the wait, pipeline still served.
          pipe_grant = bus.PipeValidW;
        end else if (!bus.PipeValidW) begin
          mcu_grant = 1'b1;
        end else begin
          pipe_grant = 1'b1;
          if (cnt >= LIMIT - CW'(1)) begin
            cnt_nxt   = LIMIT;
            state_nxt = ST_FORCE;
          end else begin
            cnt_nxt   = cnt + CW'(1);
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_FORCE: begin
        stall     = 1'b1;
        mcu_grant = bus.McuValid;
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Gated by reset so no handshake fires while the arbiter is held in reset.
  assign bus.McuReady = mcu_grant & reset;
  assign bus.StallW   = stall & reset;

`ifdef WB_ARB_PERF_EN
  assign bus.WaitCount = cnt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bus.ResultSel <= 3'b000;
      bus.RegWriteW <= 1'b0;
      bus.RdW       <= 5'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (pipe_grant) begin
        bus.ResultSel <= {1'b0, bus.PipeResultSrcW};
        bus.RdW       <= bus.PipeRdW;
        bus.RegWriteW <= (bus.PipeRdW != 5'd0);
      end else if (mcu_grant) begin
        bus.ResultSel <= 3'b100;
        bus.RdW       <= bus.McuRd;
        bus.RegWriteW <= (bus.McuRd != 5'd0);
      end else begin
        bus.RegWriteW <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_result_arbiter.sv
// Directed bench for wb_result_arbiter (STARVE_LIMIT=4, CW=3); WaitCount checks only in WB_ARB_PERF_EN builds.
module tb_wb_result_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

`ifdef WB_ARB_PERF_EN
  wb_result_arbiter_if #(.CW(3)) bus();
`else
  wb_result_arbiter_if bus();
`endif

  wb_result_arbiter #(.STARVE_LIMIT(4), .CW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Inputs change 1 time unit after a rising edge; outputs are sampled before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [1:0] src, input logic [4:0] prd,
                       input logic mv, input logic [4:0] mrd);
    bus.PipeValidW     = pv;
    bus.PipeResultSrcW = src;
    bus.PipeRdW        = prd;
    bus.McuValid       = mv;
    bus.McuRd          = mrd;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 5'd0, 1'b0, 5'd0);
    tick();
  endtask

  task automatic test_reset();
    drive(1'b0, 2'b00, 5'd0, 1'b1, 5'd3);
    #12;
    tests++; if (bus.McuReady !== 1'b0) begin fails++; $display("FAIL reset_mcuready: got %b want 0", bus.McuReady); end
    tests++; if (bus.StallW !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", bus.StallW); end
    tests++; if (bus.ResultSel !== 3'b000) begin fails++; $display("FAIL reset_sel: got %b want 000", bus.ResultSel); end
    tests++; if (bus.RegWriteW !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", bus.RegWriteW); end
    tests++; if (bus.RdW !== 5'd0) begin fails++; $display("FAIL reset_rd: got %0d want 0", bus.RdW); end
`ifdef WB_ARB_PERF_EN
    tests++; if (bus.WaitCount !== 3'd0) begin fails++; $display("FAIL reset_waitcnt: got %0d want 0", bus.WaitCount); end
`endif
    drive(1'b0, 2'b00, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_pipe_grant();
    idle();
    drive(1'b1, 2'b10, 5'd7, 1'b0, 5'd0);
    #1;
    tests++; if (bus.McuReady !== 1'b0) begin fails++; $display("FAIL pipe_mcuready: got %b want 0", bus.McuReady); end
    tick();
    tests++; if (bus.ResultSel !== 3'b010) begin fails++; $display("FAIL pipe_sel: got %b want 010", bus.ResultSel); end
    tests++; if (bus.RdW !== 5'd7) begin fails++; $display("FAIL pipe_rd: got %0d want 7", bus.RdW); end
    tests++; if (bus.RegWriteW !== 1'b1) begin fails++; $display("FAIL pipe_we: got %b want 1", bus.RegWriteW); end
    drive(1'b0, 2'b00, 5'd0, 1'b0, 5'd0);
    tick();
    // No grant: write enable drops, select and address hold.
    tests++; if (bus.RegWriteW !== 1'b0) begin fails++; $display("FAIL nogrant_we: got %b want 0", bus.RegWriteW); end
    tests++; if (bus.ResultSel !== 3'b010) begin fails++; $display("FAIL nogrant_sel_hold: got %b want 010", bus.ResultSel); end
    tests++; if (bus.RdW !== 5'd7) begin fails++; $display("FAIL nogrant_rd_hold: got %0d want 7", bus.RdW); end
  endtask

  task automatic test_mcu_grant();
    idle();
    drive(1'b0, 2'b00, 5'd0, 1'b1, 5'd9);
    #1;
    tests++; if (bus.McuReady !== 1'b1) begin fails++; $display("FAIL mcu_ready: got %b want 1", bus.McuReady); end
    tests++; if (bus.StallW !== 1'b0) begin fails++; $display("FAIL mcu_stall: got %b want 0", bus.StallW); end
    tick();
    drive(1'b0, 2'b00, 5'd0, 1'b0, 5'd0);
    tests++; if (bus.ResultSel !== 3'b100) begin fails++; $display("FAIL mcu_sel: got %b want 100", bus.ResultSel); end
    tests++; if (bus.RdW !== 5'd9) begin fails++; $display("FAIL mcu_rd: got %0d want 9", bus.RdW); end
    tests++; if (bus.RegWriteW !== 1'b1) begin fails++; $display("FAIL mcu_we: got %b want 1", bus.RegWriteW); end
  endtask

  task automatic test_starvation();
    idle();
    drive(1'b1, 2'b01, 5'd3, 1'b1, 5'd12);
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (bus.McuReady !== 1'b0 || bus.StallW !== 1'b0) begin fails++; $display("FAIL starve_lose%0d: ready=%b stall=%b want 0 0", i, bus.McuReady, bus.StallW); end
      tick();
      tests++; if (bus.ResultSel !== 3'b001 || bus.RdW !== 5'd3 || bus.RegWriteW !== 1'b1) begin fails++; $display("FAIL starve_pipe%0d: sel=%b rd=%0d we=%b want 001 3 1", i, bus.ResultSel, bus.RdW, bus.RegWriteW); end
`ifdef WB_ARB_PERF_EN
      tests++; if (bus.WaitCount !== 3'(i + 1)) begin fails++; $display("FAIL starve_waitcnt%0d: got %0d want %0d", i, bus.WaitCount, i + 1); end
`endif
    end
    #1;
    tests++; if (bus.StallW !== 1'b1) begin fails++; $display("FAIL force_stall: got %b want 1", bus.StallW); end
    tests++; if (bus.McuReady !== 1'b1) begin fails++; $display("FAIL force_ready: got %b want 1", bus.McuReady); end
    tick();
    tests++; if (bus.ResultSel !== 3'b100 || bus.RdW !== 5'd12 || bus.RegWriteW !== 1'b1) begin fails++; $display("FAIL force_result: sel=%b rd=%0d we=%b want 100 12 1", bus.ResultSel, bus.RdW, bus.RegWriteW); end
`ifdef WB_ARB_PERF_EN
    tests++; if (bus.WaitCount !== 3'd0) begin fails++; $display("FAIL force_waitcnt: got %0d want 0", bus.WaitCount); end
`endif
    // Back to IDLE: pipeline wins again even with MCU still valid.
    #1;
    tests++; if (bus.StallW !== 1'b0 || bus.McuReady !== 1'b0) begin fails++; $display("FAIL resume_ctrl: stall=%b ready=%b want 0 0", bus.StallW, bus.McuReady); end
    tick();
    tests++; if (bus.ResultSel !== 3'b001 || bus.RdW !== 5'd3) begin fails++; $display("FAIL resume_pipe: sel=%b rd=%0d want 001 3", bus.ResultSel, bus.RdW); end
  endtask

  task automatic test_x0_suppress();
    idle();
    drive(1'b1, 2'b11, 5'd0, 1'b0, 5'd0);
    tick();
    tests++; if (bus.RegWriteW !== 1'b0 || bus.ResultSel !== 3'b011) begin fails++; $display("FAIL x0_pipe: we=%b sel=%b want 0 011", bus.RegWriteW, bus.ResultSel); end
    drive(1'b0, 2'b00, 5'd0, 1'b1, 5'd0);
    #1;
    tests++; if (bus.McuReady !== 1'b1) begin fails++; $display("FAIL x0_mcu_ready: got %b want 1", bus.McuReady); end
    tick();
    tests++; if (bus.RegWriteW !== 1'b0 || bus.ResultSel !== 3'b100) begin fails++; $display("FAIL x0_mcu: we=%b sel=%b want 0 100", bus.RegWriteW, bus.ResultSel); end
  endtask

  task automatic test_wait_drop();
    idle();
    drive(1'b1, 2'b00, 5'd5, 1'b1, 5'd6);
    tick();
    drive(1'b0, 2'b00, 5'd0, 1'b0, 5'd6);
    #1;
    tests++; if (bus.McuReady !== 1'b0) begin fails++; $display("FAIL drop_ready: got %b want 0", bus.McuReady); end
    tick();
    tests++; if (bus.RegWriteW !== 1'b0) begin fails++; $display("FAIL drop_we: got %b want 0", bus.RegWriteW); end
`ifdef WB_ARB_PERF_EN
    tests++; if (bus.WaitCount !== 3'd0) begin fails++; $display("FAIL drop_waitcnt: got %0d want 0", bus.WaitCount); end
`endif
    // Counter restarted: a fresh contest needs four full losses before forcing.
    drive(1'b1, 2'b00, 5'd5, 1'b1, 5'd6);
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (bus.StallW !== 1'b0) begin fails++; $display("FAIL drop_restart%0d: stall=%b want 0", i, bus.StallW); end
      tick();
    end
    #1;
    tests++; if (bus.StallW !== 1'b1) begin fails++; $display("FAIL drop_force: stall=%b want 1", bus.StallW); end
    tick();
    // Back-to-back: WAIT then pipeline idle grants the MCU without forcing.
    idle();
    drive(1'b1, 2'b10, 5'd4, 1'b1, 5'd8);
    tick();
    drive(1'b0, 2'b00, 5'd0, 1'b1, 5'd8);
    #1;
    tests++; if (bus.McuReady !== 1'b1 || bus.StallW !== 1'b0) begin fails++; $display("FAIL b2b_ready: ready=%b stall=%b want 1 0", bus.McuReady, bus.StallW); end
    tick();
    tests++; if (bus.ResultSel !== 3'b100 || bus.RdW !== 5'd8) begin fails++; $display("FAIL b2b_result: sel=%b rd=%0d want 100 8", bus.ResultSel, bus.RdW); end
  endtask

  task automatic test_reset_in_force();
    idle();
    drive(1'b1, 2'b01, 5'd2, 1'b1, 5'd11);
    repeat (4) tick();
    #1;
    tests++; if (bus.StallW !== 1'b1) begin fails++; $display("FAIL rf_reach: stall=%b want 1", bus.StallW); end
    reset = 1'b0;
    #1;
    tests++; if (bus.McuReady !== 1'b0 || bus.StallW !== 1'b0) begin fails++; $display("FAIL rf_ctrl: ready=%b stall=%b want 0 0", bus.McuReady, bus.StallW); end
    @(negedge clk);
    drive(1'b0, 2'b00, 5'd0, 1'b1, 5'd11);
    reset = 1'b1;
    #1;
    // Pending MCU result still presented and now accepted from IDLE.
    tests++; if (bus.McuReady !== 1'b1) begin fails++; $display("FAIL rf_pending: ready=%b want 1", bus.McuReady); end
    tests++; if (bus.RegWriteW !== 1'b0 || bus.ResultSel !== 3'b000) begin fails++; $display("FAIL rf_regs: we=%b sel=%b want 0 000", bus.RegWriteW, bus.ResultSel); end
    tick();
    tests++; if (bus.ResultSel !== 3'b100 || bus.RdW !== 5'd11) begin fails++; $display("FAIL rf_mcu: sel=%b rd=%0d want 100 11", bus.ResultSel, bus.RdW); end
  endtask

  initial begin
    drive(1'b0, 2'b00, 5'd0, 1'b0, 5'd0);
    test_reset();
    test_pipe_grant();
    test_mcu_grant();
    test_starvation();
    test_x0_suppress();
    test_wait_drop();
    test_reset_in_force();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
